// File: rtl/seq_match_pkg.sv
// Shared constants, width helpers and the saturating-increment function for the
// seq_match streaming pattern detector.
package seq_match_pkg;

   localparam int SEQ_DEPTH_DEF = 8;
   localparam int SEQ_W_DEF     = 8;
   localparam int SEQ_CNT_W_DEF = 16;

   typedef logic [$clog2(SEQ_DEPTH_DEF)-1:0]   idx_t;
   typedef logic [$clog2(SEQ_DEPTH_DEF+1)-1:0] len_t;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int len_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] top_v;
      top_v = {32{1'b1}} >> (32 - w);
      if (v == top_v) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational comparator: pattern position i is checked against history
// entry len-1-i (history[0] is the newest symbol); wildcards and i >= len pass.
module seq_match_cmp
   import seq_match_pkg::*;
#(
   parameter int DEPTH = SEQ_DEPTH_DEF,
   parameter int W     = SEQ_W_DEF,
   localparam int LW   = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0][W-1:0] hist,
   input  logic [DEPTH-1:0][W-1:0] pat,
   input  logic [DEPTH-1:0]        care,
   input  logic [LW-1:0]           len,
   output logic                    hit
);

   logic [W-1:0] lane_sym_s;

   // Per-lane select of the aligned history symbol and AND-reduction of lane results.
   always_comb begin
      hit        = (len != {LW{1'b0}});
      lane_sym_s = {W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         lane_sym_s = {W{1'b0}};
         for (int j = 0; j < DEPTH; j++) begin
            if (j == int'(len) - 1 - i) begin
               lane_sym_s = hist[j];
            end else begin
               lane_sym_s = lane_sym_s;
            end
         end
         if ((i < int'(len)) && care[i] && (pat[i] != lane_sym_s)) begin
            hit = 1'b0;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/seq_match.sv
// Streaming symbol-sequence detector with per-position wildcards, overlap
// detection, a sticky found flag and a saturating hit counter.
module seq_match
   import seq_match_pkg::*;
#(
   parameter int DEPTH = SEQ_DEPTH_DEF,
   parameter int W     = SEQ_W_DEF,
   parameter int CNT_W = SEQ_CNT_W_DEF,
   localparam int IW   = idx_w(DEPTH),
   localparam int LW   = len_w(DEPTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             d_valid,
   input  logic [W-1:0]     d,
   input  logic             cfg_we,
   input  logic [IW-1:0]    cfg_idx,
   input  logic [W-1:0]     cfg_sym,
   input  logic             cfg_care,
   input  logic             cfg_len_we,
   input  logic [LW-1:0]    cfg_len,
   input  logic             stat_clr,
   output logic             match,
   output logic             found,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] ZERO_L  = {LW{1'b0}};

   logic [DEPTH-1:0][W-1:0] pat_r;
   logic [DEPTH-1:0]        care_r;
   logic [LW-1:0]           len_r;
   logic [DEPTH-1:0][W-1:0] hist_r;
   logic [LW-1:0]           fill_r;
   logic                    match_r;
   logic                    found_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    armed_r;

   logic                    len_ok_s;
   logic                    flush_s;
   logic                    accept_s;
   logic [LW-1:0]           fill_inc_s;
   logic [LW-1:0]           fill_nxt_s;
   logic [LW-1:0]           len_nxt_s;
   logic [DEPTH-1:0][W-1:0] hist_nxt_s;
   logic                    cmp_hit_s;
   logic                    hit_s;
   logic                    armed_nxt_s;

   seq_match_cmp #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_cmp (
      .hist (hist_nxt_s),
      .pat  (pat_r),
      .care (care_r),
      .len  (len_r),
      .hit  (cmp_hit_s)
   );

   // Accept/flush decode, post-shift history, fill/len next state and hit qualification.
   always_comb begin
      len_ok_s = cfg_len_we && (cfg_len <= DEPTH_L);
      flush_s  = cfg_we || len_ok_s;
      accept_s = d_valid && !flush_s;

      if (fill_r == DEPTH_L) begin
         fill_inc_s = fill_r;
      end else begin
         fill_inc_s = fill_r + LW'(1'b1);
      end

      if (accept_s) begin
         hist_nxt_s = {hist_r[DEPTH-2:0], d};
      end else begin
         hist_nxt_s = hist_r;
      end

      if (flush_s) begin
         fill_nxt_s = ZERO_L;
      end else if (accept_s) begin
         fill_nxt_s = fill_inc_s;
      end else begin
         fill_nxt_s = fill_r;
      end

      if (len_ok_s) begin
         len_nxt_s = cfg_len;
      end else begin
         len_nxt_s = len_r;
      end

      // Config writes never coincide with an accepted symbol, so the registered pattern is current.
      hit_s       = accept_s && cmp_hit_s && (fill_inc_s >= len_r);
      armed_nxt_s = (len_nxt_s != ZERO_L) && (fill_nxt_s >= len_nxt_s);
   end

   // State and output registers; stat_clr overrides a coincident hit for the stats only.
   always_ff @(posedge clk) begin
      if (clr) begin
         pat_r   <= '{default: {W{1'b0}}};
         care_r  <= {DEPTH{1'b0}};
         len_r   <= ZERO_L;
         hist_r  <= '{default: {W{1'b0}}};
         fill_r  <= ZERO_L;
         match_r <= 1'b0;
         found_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         armed_r <= 1'b0;
      end else begin
         if (cfg_we) begin
            pat_r[cfg_idx]  <= cfg_sym;
            care_r[cfg_idx] <= cfg_care;
         end
         len_r   <= len_nxt_s;
         hist_r  <= hist_nxt_s;
         fill_r  <= fill_nxt_s;
         match_r <= hit_s;
         armed_r <= armed_nxt_s;
         if (stat_clr) begin
            found_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
         end else if (hit_s) begin
            found_r <= 1'b1;
            cnt_r   <= CNT_W'(sat_inc(32'(cnt_r), CNT_W));
         end
      end
   end

   assign match     = match_r;
   assign found     = found_r;
   assign match_cnt = cnt_r;
   assign armed     = armed_r;

endmodule
